// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the five-stage MIPS core (E/M and M/W boundaries).
// Carries valid, Tnew countdown, first-wins exception code, delay-slot flag and a stall counter.
module pipe_stage_reg #(
   parameter int unsigned         ADDR_W   = 5,
   parameter int unsigned         DATA_W   = 32,
   parameter int unsigned         TNEW_W   = 2,
   parameter int unsigned         EXC_W    = 5,
   parameter int unsigned         CNT_W    = 16,
   parameter logic [DATA_W-1:0]   RESET_PC = 32'h0000_3000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall_i,
   input  logic                flush_i,
   input  logic                valid_i,
   input  logic [DATA_W-1:0]   pc_i,
   input  logic [DATA_W-1:0]   instr_i,
   input  logic [ADDR_W-1:0]   wb_addr_i,
   input  logic [DATA_W-1:0]   wb_data_i,
   input  logic [DATA_W-1:0]   alu_i,
   input  logic [DATA_W-1:0]   rs2_i,
   input  logic [TNEW_W-1:0]   tnew_i,
   input  logic [EXC_W-1:0]    exc_i,
   input  logic [EXC_W-1:0]    exc_new_i,
   input  logic                bd_i,
   output logic                valid_o,
   output logic [DATA_W-1:0]   pc_o,
   output logic [DATA_W-1:0]   instr_o,
   output logic [DATA_W-1:0]   wb_data_o,
   output logic [DATA_W-1:0]   alu_o,
   output logic [DATA_W-1:0]   rs2_o,
   output logic [ADDR_W-1:0]   wb_addr_o,
   output logic [TNEW_W-1:0]   tnew_o,
   output logic [EXC_W-1:0]    exc_o,
   output logic                bd_o,
   output logic                fwd_ok_o,
   output logic [CNT_W-1:0]    stall_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [TNEW_W-1:0] tnew_dec;
   logic [EXC_W-1:0]  exc_merged;

   // Tnew saturates at zero; the earlier stage's exception always takes precedence.
   always_comb begin
      tnew_dec   = (tnew_i == '0) ? '0 : tnew_i - TNEW_W'(1);
      exc_merged = (exc_i != '0) ? exc_i : exc_new_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_o   <= 1'b0;
         pc_o      <= RESET_PC;
         instr_o   <= '0;
         wb_data_o <= '0;
         alu_o     <= '0;
         rs2_o     <= '0;
         wb_addr_o <= '0;
         tnew_o    <= '0;
         exc_o     <= '0;
         bd_o      <= 1'b0;
      end else if (flush_i) begin
         // Bubble keeps a meaningful macro-PC and delay-slot flag for exception-PC logic.
         valid_o   <= 1'b0;
         pc_o      <= valid_i ? pc_i : RESET_PC;
         instr_o   <= '0;
         wb_data_o <= '0;
         alu_o     <= '0;
         rs2_o     <= '0;
         wb_addr_o <= '0;
         tnew_o    <= '0;
         exc_o     <= '0;
         bd_o      <= bd_i;
      end else if (!stall_i) begin
         valid_o   <= valid_i;
         pc_o      <= pc_i;
         instr_o   <= instr_i;
         wb_data_o <= wb_data_i;
         alu_o     <= alu_i;
         rs2_o     <= rs2_i;
         wb_addr_o <= valid_i ? wb_addr_i : '0;
         tnew_o    <= valid_i ? tnew_dec : '0;
         exc_o     <= valid_i ? exc_merged : '0;
         bd_o      <= bd_i;
      end
   end

   // Counts every stalled cycle, flush or not, and sticks at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_o <= '0;
      end else if (stall_i && (stall_cnt_o != CNT_MAX)) begin
         stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
   end

   assign fwd_ok_o = valid_o && (tnew_o == '0) && (wb_addr_o != '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed test-plan cases plus random stimulus
// against a cycle-level reference model; a CNT_W=2 instance covers counter saturation.
module tb_pipe_stage_reg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int TNEW_W = 2;
   localparam int EXC_W  = 5;
   localparam logic [31:0] RPC = 32'h0000_3000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset, stall_i, flush_i, valid_i, bd_i;
   logic [DATA_W-1:0] pc_i, instr_i, wb_data_i, alu_i, rs2_i;
   logic [ADDR_W-1:0] wb_addr_i;
   logic [TNEW_W-1:0] tnew_i;
   logic [EXC_W-1:0]  exc_i, exc_new_i;

   logic              valid_o, bd_o, fwd_ok_o;
   logic [DATA_W-1:0] pc_o, instr_o, wb_data_o, alu_o, rs2_o;
   logic [ADDR_W-1:0] wb_addr_o;
   logic [TNEW_W-1:0] tnew_o;
   logic [EXC_W-1:0]  exc_o;
   logic [15:0]       stall_cnt_o;

   logic              b_valid, b_bd, b_fwd;
   logic [DATA_W-1:0] b_pc, b_instr, b_wb_data, b_alu, b_rs2;
   logic [ADDR_W-1:0] b_wb_addr;
   logic [TNEW_W-1:0] b_tnew;
   logic [EXC_W-1:0]  b_exc;
   logic [1:0]        b_cnt;

   pipe_stage_reg #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
      .pc_i(pc_i), .instr_i(instr_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .alu_i(alu_i), .rs2_i(rs2_i), .tnew_i(tnew_i), .exc_i(exc_i), .exc_new_i(exc_new_i),
      .bd_i(bd_i), .valid_o(valid_o), .pc_o(pc_o), .instr_o(instr_o), .wb_data_o(wb_data_o),
      .alu_o(alu_o), .rs2_o(rs2_o), .wb_addr_o(wb_addr_o), .tnew_o(tnew_o), .exc_o(exc_o),
      .bd_o(bd_o), .fwd_ok_o(fwd_ok_o), .stall_cnt_o(stall_cnt_o)
   );

   pipe_stage_reg #(.CNT_W(2)) dut_small (
      .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
      .pc_i(pc_i), .instr_i(instr_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .alu_i(alu_i), .rs2_i(rs2_i), .tnew_i(tnew_i), .exc_i(exc_i), .exc_new_i(exc_new_i),
      .bd_i(bd_i), .valid_o(b_valid), .pc_o(b_pc), .instr_o(b_instr), .wb_data_o(b_wb_data),
      .alu_o(b_alu), .rs2_o(b_rs2), .wb_addr_o(b_wb_addr), .tnew_o(b_tnew), .exc_o(b_exc),
      .bd_o(b_bd), .fwd_ok_o(b_fwd), .stall_cnt_o(b_cnt)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   // Reference model state, kept as plain integers.
   int          m_valid, m_bd, m_tnew, m_exc, m_wb_addr, m_cnt16, m_cnt2;
   logic [31:0] m_pc, m_instr, m_wb_data, m_alu, m_rs2;

   task automatic model_edge();
      if (reset) begin
         m_valid = 0; m_bd = 0; m_tnew = 0; m_exc = 0; m_wb_addr = 0;
         m_pc = RPC; m_instr = 0; m_wb_data = 0; m_alu = 0; m_rs2 = 0;
         m_cnt16 = 0; m_cnt2 = 0;
      end else begin
         if (stall_i) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
         end
         if (flush_i) begin
            m_valid = 0; m_instr = 0; m_wb_addr = 0; m_tnew = 0; m_exc = 0;
            m_wb_data = 0; m_alu = 0; m_rs2 = 0;
            m_pc = valid_i ? pc_i : RPC;
            m_bd = bd_i;
         end else if (!stall_i) begin
            m_valid = valid_i; m_pc = pc_i; m_instr = instr_i;
            m_wb_data = wb_data_i; m_alu = alu_i; m_rs2 = rs2_i; m_bd = bd_i;
            if (valid_i) begin
               m_wb_addr = wb_addr_i;
               m_tnew = (int'(tnew_i) > 0) ? int'(tnew_i) - 1 : 0;
               m_exc = (exc_i != 0) ? int'(exc_i) : int'(exc_new_i);
            end else begin
               m_wb_addr = 0; m_tnew = 0; m_exc = 0;
            end
         end
      end
   endtask

   task automatic compare_all();
      int fwd;
      fwd = (m_valid != 0 && m_tnew == 0 && m_wb_addr != 0) ? 1 : 0;
      check("valid", valid_o, m_valid);
      check("pc", pc_o, m_pc);
      check("instr", instr_o, m_instr);
      check("wb_data", wb_data_o, m_wb_data);
      check("alu", alu_o, m_alu);
      check("rs2", rs2_o, m_rs2);
      check("wb_addr", wb_addr_o, m_wb_addr);
      check("tnew", tnew_o, m_tnew);
      check("exc", exc_o, m_exc);
      check("bd", bd_o, m_bd);
      check("fwd_ok", fwd_ok_o, fwd);
      check("stall_cnt", stall_cnt_o, m_cnt16);
      check("s_valid", b_valid, m_valid);
      check("s_pc", b_pc, m_pc);
      check("s_wb_addr", b_wb_addr, m_wb_addr);
      check("s_exc", b_exc, m_exc);
      check("s_fwd", b_fwd, fwd);
      check("s_cnt", b_cnt, m_cnt2);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic clear_inputs();
      reset = 0; stall_i = 0; flush_i = 0; valid_i = 0; bd_i = 0;
      pc_i = 0; instr_i = 0; wb_data_i = 0; alu_i = 0; rs2_i = 0;
      wb_addr_i = 0; tnew_i = 0; exc_i = 0; exc_new_i = 0;
   endtask

   task automatic randomize_payload();
      pc_i = $urandom; instr_i = $urandom; wb_data_i = $urandom;
      alu_i = $urandom; rs2_i = $urandom; wb_addr_i = ADDR_W'($urandom);
      tnew_i = TNEW_W'($urandom); bd_i = 1'($urandom);
      exc_i = ($urandom_range(0, 2) == 0) ? EXC_W'($urandom) : '0;
      exc_new_i = ($urandom_range(0, 1) == 0) ? EXC_W'($urandom) : '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1;
      step();
      reset = 0;
   endtask

   initial begin
      clear_inputs();

      // 1: reset for two cycles, then release with everything low
      reset = 1;
      step();
      step();
      check("rst_pc", pc_o, 32'h0000_3000);
      check("rst_fwd", fwd_ok_o, 0);
      check("rst_cnt", stall_cnt_o, 0);
      reset = 0;
      step();
      check("rel_pc", pc_o, 0);
      check("rel_valid", valid_o, 0);

      // 2: load and Tnew countdown
      valid_i = 1; pc_i = 32'h3004; wb_addr_i = 5; tnew_i = 1; alu_i = 32'hDEAD_BEEF;
      step();
      check("ld_valid", valid_o, 1);
      check("ld_tnew", tnew_o, 0);
      check("ld_alu", alu_o, 32'hDEAD_BEEF);
      check("ld_fwd", fwd_ok_o, 1);
      tnew_i = 0;
      step();
      check("tnew_nowrap", tnew_o, 0);
      tnew_i = 3;
      step();
      check("tnew_3", tnew_o, 2);
      check("tnew_3_fwd", fwd_ok_o, 0);

      // 3: stall holds payload, flush during stall
      do_reset();
      valid_i = 1; pc_i = 32'h3010; wb_addr_i = 9; tnew_i = 0; alu_i = 32'h1234_5678;
      step();
      stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         randomize_payload();
         step();
         check("stall_pc", pc_o, 32'h3010);
         check("stall_alu", alu_o, 32'h1234_5678);
      end
      check("stall_cnt3", stall_cnt_o, 3);
      flush_i = 1; valid_i = 1; pc_i = 32'h3020; wb_addr_i = 11;
      step();
      check("fl_valid", valid_o, 0);
      check("fl_wb_addr", wb_addr_o, 0);
      check("fl_pc", pc_o, 32'h3020);
      check("fl_cnt4", stall_cnt_o, 4);
      stall_i = 0; flush_i = 0;

      // 4: exception merge and delay-slot flag
      valid_i = 1; wb_addr_i = 3; exc_i = 0; exc_new_i = 12; bd_i = 0;
      step();
      check("exc_new", exc_o, 12);
      exc_i = 4;
      step();
      check("exc_first", exc_o, 4);
      flush_i = 1;
      step();
      check("exc_flush", exc_o, 0);
      bd_i = 1;
      step();
      check("bd_flush", bd_o, 1);
      valid_i = 0;
      step();
      check("fl_nosrc_pc", pc_o, 32'h0000_3000);
      flush_i = 0; bd_i = 0; exc_i = 0; exc_new_i = 0;

      // 5: forwarding qualifier
      valid_i = 1; wb_addr_i = 0; tnew_i = 0;
      step();
      check("fwd_r0", fwd_ok_o, 0);
      valid_i = 0; wb_addr_i = 7; exc_i = 6;
      step();
      check("inv_wb_addr", wb_addr_o, 0);
      check("inv_exc", exc_o, 0);
      check("inv_fwd", fwd_ok_o, 0);

      // 6: 2-bit counter saturation, and reset in the middle of a stall
      do_reset();
      stall_i = 1;
      for (int i = 1; i <= 6; i++) begin
         step();
         check("sat_cnt", b_cnt, (i < 3) ? i : 3);
      end
      do_reset();
      stall_i = 1;
      for (int i = 0; i < 3; i++) step();
      reset = 1;
      step();
      check("mid_rst_cnt", b_cnt, 0);
      check("mid_rst_pc", b_pc, 32'h0000_3000);
      reset = 0; stall_i = 0; valid_i = 1; pc_i = 32'h3040; wb_addr_i = 2;
      step();
      check("post_rst_ld", pc_o, 32'h3040);

      // random traffic against the reference model
      for (int n = 0; n < 500; n++) begin
         randomize_payload();
         valid_i = ($urandom_range(0, 3) != 0);
         stall_i = ($urandom_range(0, 3) == 0);
         flush_i = ($urandom_range(0, 7) == 0);
         reset   = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 9) == 0) tnew_i = 0;
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
